// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: MENU/PLAYING/DEAD/WIN flow, level tracking,
// frame-based countdowns, sound-trigger and frog-respawn pulses.
module game_state_ctrl #(
    parameter int unsigned MAX_LEVEL   = 9,
    parameter int unsigned DEAD_FRAMES = 90,
    parameter int unsigned WIN_FRAMES  = 120,
    parameter int unsigned TIMER_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up_tick,
    input  logic       btn_down_tick,
    input  logic       btn_left_tick,
    input  logic       btn_right_tick,
    input  logic       collision,
    input  logic       at_goal,
    output logic [1:0] state,
    output logic [3:0] level,
    output logic [3:0] sound_trig,
    output logic       frog_reset
);

    localparam logic [3:0] SND_UI_PRESS   = 4'b0001;
    localparam logic [3:0] SND_NEXTLEVEL  = 4'b0010;
    localparam logic [3:0] SND_CRASH      = 4'b0100;
    localparam logic [3:0] SND_CELEBRATE  = 4'b1000;

    localparam logic [3:0]         LEVEL_MAX = 4'(MAX_LEVEL);
    localparam logic [TIMER_W-1:0] DEAD_LOAD = TIMER_W'(DEAD_FRAMES);
    localparam logic [TIMER_W-1:0] WIN_LOAD  = TIMER_W'(WIN_FRAMES);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        PLAYING = 2'd1,
        DEAD    = 2'd2,
        WIN     = 2'd3
    } state_t;

    state_t             cur;
    logic [TIMER_W-1:0] timer;
    logic               goal_armed;
    logic               any_btn;

    assign any_btn = btn_up_tick | btn_down_tick | btn_left_tick | btn_right_tick;
    assign state   = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= MENU;
            level      <= 4'd1;
            timer      <= '0;
            goal_armed <= 1'b1;
            sound_trig <= '0;
            frog_reset <= 1'b0;
        end else begin
            sound_trig <= '0;
            frog_reset <= 1'b0;
            case (cur)
                MENU: begin
                    if (any_btn) begin
                        cur        <= PLAYING;
                        level      <= 4'd1;
                        goal_armed <= 1'b1;
                        sound_trig <= SND_UI_PRESS;
                        frog_reset <= 1'b1;
                    end
                end
                PLAYING: begin
                    // goal_armed blocks repeat level-ups while the respawned frog
                    // is still reported on the goal row.
                    if (collision) begin
                        cur        <= DEAD;
                        timer      <= DEAD_LOAD;
                        sound_trig <= SND_CRASH;
                    end else if (at_goal && goal_armed) begin
                        if (level < LEVEL_MAX) begin
                            level      <= level + 4'd1;
                            goal_armed <= 1'b0;
                            sound_trig <= SND_NEXTLEVEL;
                            frog_reset <= 1'b1;
                        end else begin
                            cur        <= WIN;
                            timer      <= WIN_LOAD;
                            sound_trig <= SND_CELEBRATE;
                        end
                    end else if (!at_goal) begin
                        goal_armed <= 1'b1;
                    end
                end
                DEAD: begin
                    if (frame_tick && (timer != '0)) begin
                        timer <= timer - TIMER_ONE;
                        if (timer == TIMER_ONE) begin
                            cur <= MENU;
                        end
                    end
                end
                WIN: begin
                    // Buttons only count once the lockout has fully expired.
                    if (timer != '0) begin
                        if (frame_tick) begin
                            timer <= timer - TIMER_ONE;
                        end
                    end else if (any_btn) begin
                        cur        <= MENU;
                        sound_trig <= SND_UI_PRESS;
                    end
                end
                default: begin
                    cur <= MENU;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: directed stimulus pushes expected
// outputs, a monitor pops and compares one entry per clock.
module tb_game_state_ctrl;

    localparam int unsigned MAXL  = 5;
    localparam int unsigned DEADF = 90;
    localparam int unsigned WINF  = 120;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up_tick = 1'b0;
    logic       btn_down_tick = 1'b0;
    logic       btn_left_tick = 1'b0;
    logic       btn_right_tick = 1'b0;
    logic       collision = 1'b0;
    logic       at_goal = 1'b0;
    logic [1:0] state;
    logic [3:0] level;
    logic [3:0] sound_trig;
    logic       frog_reset;

    game_state_ctrl #(
        .MAX_LEVEL  (MAXL),
        .DEAD_FRAMES(DEADF),
        .WIN_FRAMES (WINF),
        .TIMER_W    (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .btn_up_tick   (btn_up_tick),
        .btn_down_tick (btn_down_tick),
        .btn_left_tick (btn_left_tick),
        .btn_right_tick(btn_right_tick),
        .collision     (collision),
        .at_goal       (at_goal),
        .state         (state),
        .level         (level),
        .sound_trig    (sound_trig),
        .frog_reset    (frog_reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [3:0] lv;
        logic [3:0] snd;
        logic       fr;
        string      nm;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] e_st = 2'd0;
    logic [3:0] e_lv = 4'd1;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [3:0] btn, input logic ft,
                        input logic col, input logic goal,
                        input logic [3:0] snd, input logic fr, input string nm);
        exp_t e;
        @(negedge clk);
        rst        = r;
        {btn_up_tick, btn_down_tick, btn_left_tick, btn_right_tick} = btn;
        frame_tick = ft;
        collision  = col;
        at_goal    = goal;
        e.st  = e_st;
        e.lv  = e_lv;
        e.snd = snd;
        e.fr  = fr;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic level_up(input logic [3:0] new_lv, input string nm);
        e_lv = new_lv;
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, nm);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "goal_drop");
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (state !== e.st || level !== e.lv || sound_trig !== e.snd || frog_reset !== e.fr) begin
                n_bad++;
                $display("FAIL %s: got state=%0d level=%0d snd=%b frog=%b, want state=%0d level=%0d snd=%b frog=%b",
                         e.nm, state, level, sound_trig, frog_reset, e.st, e.lv, e.snd, e.fr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, with every other input active to show reset priority.
        e_st = 2'd0; e_lv = 4'd1;
        step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "reset");
        step(1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, "reset_priority");
        repeat (10) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "menu_idle");
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, "menu_ignores_hazard");

        e_st = 2'd1;
        step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, "menu_to_play");

        // Held at_goal gives a single level-up.
        e_lv = 4'd2;
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, "levelup_first");
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "goal_hold_guard");
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "goal_hold_guard");
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "goal_drop");
        level_up(4'd3, "levelup_rearmed");
        step(1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "play_buttons_ignored");
        level_up(4'd4, "levelup_4");
        level_up(4'd5, "levelup_5");

        // Collision wins over goal; DEAD countdown with buttons ignored.
        e_st = 2'd2;
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, "crash_priority");
        step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "dead_no_tick");
        for (int i = 0; i < int'(DEADF) - 1; i++)
            step(1'b0, (i % 3 == 0) ? 4'hF : 4'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "dead_count");
        e_st = 2'd0;
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "dead_to_menu");
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "menu_holds_level");

        e_st = 2'd1; e_lv = 4'd1;
        step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, "replay_level_reset");
        level_up(4'd2, "levelup_r2");
        level_up(4'd3, "levelup_r3");
        level_up(4'd4, "levelup_r4");
        level_up(4'd5, "levelup_r5");

        // Clearing the top level wins; level does not wrap.
        e_st = 2'd3;
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, "win_entry");
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "win_hold");
        for (int i = 0; i < int'(WINF) - 1; i++)
            step(1'b0, 4'hF, 1'b1, i[0], 1'b0, 4'b0000, 1'b0, "win_lockout");
        step(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "win_last_tick_with_btn");
        repeat (3) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "win_wait");
        e_st = 2'd0;
        step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, "win_to_menu");

        // Reset mid-countdown.
        e_st = 2'd1; e_lv = 4'd1;
        step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, "menu_to_play2");
        e_st = 2'd2;
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, "crash2");
        repeat (50) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "dead_count2");
        e_st = 2'd0;
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "rst_mid_dead");
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "after_rst_idle");

        // Timer restarts from a full load after the reset.
        e_st = 2'd1;
        step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, "menu_to_play3");
        e_st = 2'd2;
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, "crash3");
        repeat (DEADF - 1) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "dead_count3");
        e_st = 2'd0;
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "dead_to_menu3");

        // Reset from PLAYING at level 2 returns to level 1.
        e_st = 2'd1;
        step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, "menu_to_play4");
        e_lv = 4'd2;
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, "levelup_4b");
        e_st = 2'd0; e_lv = 4'd1;
        step(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "rst_from_play");
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "final_idle");

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
